// File: rtl/lk_iter_ctrl.sv
// Level/iteration sequencer for the pyramidal LK displacement accumulator.
// Optional watchdog is compiled in when LK_CTRL_TIMEOUT_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// REQ    | it_req raised, waiting for it_ack
// WAIT_D | waiting for dr/dc from the pipeline (accumulator enabled)
// EVAL   | accumulator settles; decide next iteration / level end
// SHIFT  | one-cycle shift_d pulse, step to the next finer level
// FIN    | one-cycle done pulse
module lk_iter_ctrl #(
    parameter int NUM_LEVELS = 3,
    parameter int MAX_ITER   = 5,
    parameter int MAX_D      = 32,
    parameter int EPS        = 67109,
    parameter int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    parameter int IT_W       = $clog2(MAX_ITER + 1),
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LVL_W-1:0] level,
    output logic [IT_W-1:0]  iter_cnt,
    output logic             it_req,
    input  logic             it_ack,
    input  logic             d_valid,
    input  logic [MAX_D-1:0] dr,
    input  logic [MAX_D-1:0] dc,
    output logic             acc_enable,
    output logic             shift_d,
    output logic             converged,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_D, S_EVAL, S_SHIFT, S_FIN
    } state_t;

    localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(NUM_LEVELS - 1);
    localparam logic [IT_W-1:0]  IT_MAX  = IT_W'(MAX_ITER);
    localparam logic [MAX_D:0]   EPS_V   = (MAX_D + 1)'(EPS);

    state_t             r_state, w_state_nx;
    logic               r_busy, w_busy_nx;
    logic               r_done, w_done_nx;
    logic               r_it_req, w_it_req_nx;
    logic               r_shift_d, w_shift_nx;
    logic [LVL_W-1:0]   r_level, w_level_nx;
    logic [IT_W-1:0]    r_iter_cnt, w_iter_nx;
    logic               r_converged, w_conv_nx;
    logic               r_conv_flag, w_flag_nx;
    logic               w_expire;

    // One extra bit so that the most negative increment has a representable magnitude.
    logic [MAX_D:0] w_dr_ext, w_dc_ext, w_dr_abs, w_dc_abs;
    logic           w_conv;

    assign w_dr_ext = {dr[MAX_D-1], dr};
    assign w_dc_ext = {dc[MAX_D-1], dc};
    assign w_dr_abs = w_dr_ext[MAX_D] ? (~w_dr_ext + (MAX_D + 1)'(1)) : w_dr_ext;
    assign w_dc_abs = w_dc_ext[MAX_D] ? (~w_dc_ext + (MAX_D + 1)'(1)) : w_dc_ext;
    assign w_conv   = (w_dr_abs < EPS_V) && (w_dc_abs < EPS_V);

`ifdef LK_CTRL_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_REQ || r_state == S_WAIT_D) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    // A d_valid landing on the expiry cycle is still accepted.
    assign w_expire = (r_state == S_REQ || r_state == S_WAIT_D) &&
                      (r_wd_cnt == WD_W'(TIMEOUT - 1)) &&
                      !(r_state == S_WAIT_D && d_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_timeout_err <= 1'b0;
        end else if (w_expire) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_expire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_it_req    <= 1'b0;
            r_shift_d   <= 1'b0;
            r_level     <= LVL_TOP;
            r_iter_cnt  <= '0;
            r_converged <= 1'b0;
            r_conv_flag <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_it_req    <= w_it_req_nx;
            r_shift_d   <= w_shift_nx;
            r_level     <= w_level_nx;
            r_iter_cnt  <= w_iter_nx;
            r_converged <= w_conv_nx;
            r_conv_flag <= w_flag_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_it_req_nx = 1'b0;
        w_shift_nx  = 1'b0;
        w_level_nx  = r_level;
        w_iter_nx   = r_iter_cnt;
        w_conv_nx   = r_converged;
        w_flag_nx   = r_conv_flag;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_level_nx = LVL_TOP;
                    w_iter_nx  = '0;
                    w_conv_nx  = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (w_expire) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = S_FIN;
                end else if (r_it_req && it_ack) begin
                    w_state_nx = S_WAIT_D;
                end else begin
                    w_it_req_nx = 1'b1;
                end
            end
            S_WAIT_D: begin
                if (d_valid) begin
                    w_flag_nx  = w_conv;
                    w_iter_nx  = r_iter_cnt + IT_W'(1);
                    w_state_nx = S_EVAL;
                end else if (w_expire) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = S_FIN;
                end
            end
            S_EVAL: begin
                if (r_conv_flag || r_iter_cnt == IT_MAX) begin
                    w_conv_nx = r_conv_flag;
                    if (r_level == '0) begin
                        w_done_nx  = 1'b1;
                        w_state_nx = S_FIN;
                    end else begin
                        w_shift_nx = 1'b1;
                        w_state_nx = S_SHIFT;
                    end
                end else begin
                    w_state_nx = S_REQ;
                end
            end
            S_SHIFT: begin
                w_level_nx = r_level - LVL_W'(1);
                w_iter_nx  = '0;
                w_state_nx = S_REQ;
            end
            S_FIN: begin
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign acc_enable = d_valid && (r_state == S_WAIT_D);
    assign busy       = r_busy;
    assign done       = r_done;
    assign it_req     = r_it_req;
    assign shift_d    = r_shift_d;
    assign level      = r_level;
    assign iter_cnt   = r_iter_cnt;
    assign converged  = r_converged;

endmodule

// File: tb/tb_lk_iter_ctrl.sv
// Self-checking bench for lk_iter_ctrl: directed and randomized flows against a
// level/iteration reference model.
module tb_lk_iter_ctrl;
    localparam int NL  = 3;
    localparam int MI  = 5;
    localparam int MD  = 32;
    localparam int EPS = 67109;
    localparam int TO  = 16;
    localparam int LW  = 2;
    localparam int IW  = 3;
    localparam logic [31:0] ONE = 32'h0400_0000;

    logic          clk = 1'b0;
    logic          reset, start, it_ack, d_valid;
    logic [MD-1:0] dr, dc;
    logic          busy, done, it_req, acc_enable, shift_d, converged, timeout_err;
    logic [LW-1:0] level;
    logic [IW-1:0] iter_cnt;

    int checks   = 0;
    int failures = 0;

    logic        mon_clr = 1'b0;
    int          mon_acc, mon_shift, mon_done, mon_overlap;
    logic [31:0] st_dr[$], st_dc[$];

    lk_iter_ctrl #(.NUM_LEVELS(NL), .MAX_ITER(MI), .MAX_D(MD), .EPS(EPS),
                   .LVL_W(LW), .IT_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .level(level), .iter_cnt(iter_cnt), .it_req(it_req), .it_ack(it_ack),
        .d_valid(d_valid), .dr(dr), .dc(dc), .acc_enable(acc_enable),
        .shift_d(shift_d), .converged(converged), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_clr) begin
            mon_acc <= 0; mon_shift <= 0; mon_done <= 0; mon_overlap <= 0;
        end else begin
            if (acc_enable) mon_acc <= mon_acc + 1;
            if (shift_d) mon_shift <= mon_shift + 1;
            if (done) mon_done <= mon_done + 1;
            if (acc_enable && shift_d) mon_overlap <= mon_overlap + 1;
        end
    end

    function automatic bit is_small(logic [31:0] v);
        longint a;
        a = longint'($signed(v));
        if (a < 0) a = -a;
        return a < EPS;
    endfunction

    function automatic logic [31:0] gen_val(int kind);
        case (kind)
            0: return 32'h0;
            1: return 32'($signed($urandom_range(0, 2*(EPS-1))) - (EPS-1));
            2: return ($urandom_range(0, 1) != 0) ? 32'(EPS) : 32'(-EPS);
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic fill_const(input int n, input logic [31:0] vr, input logic [31:0] vc);
        for (int i = 0; i < n; i++) begin st_dr.push_back(vr); st_dc.push_back(vc); end
    endtask

    // Runs one flow; the model tracks level, iteration and convergence from the stimulus.
    task automatic drive_run(input bit spur_start);
        int m_lvl, m_it, m_acc, cyc, dv_cyc, exp_gap;
        bit m_conv, m_fin, first_req, seen_done, c;
        logic [31:0] pdr, pdc;
        m_lvl = NL - 1; m_it = 0; m_acc = 0; cyc = 0; dv_cyc = 0; exp_gap = 3;
        m_conv = 0; m_fin = 0; first_req = 1; seen_done = 0;
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy: got %b exp 1", busy); end
        checks++; if (it_req !== 1'b0) begin failures++; $display("FAIL start_req_early: got %b exp 0", it_req); end
        @(negedge clk);
        checks++; if (it_req !== 1'b1) begin failures++; $display("FAIL start_req_latency: got %b exp 1", it_req); end
        for (int t = 0; t < 800; t++) begin
            if (done) begin seen_done = 1; break; end
            if (it_req) begin
                if (m_fin) begin
                    checks++; failures++; $display("FAIL extra_req: got it_req=1 exp done");
                    break;
                end
                if (!first_req) begin
                    checks++;
                    if (cyc - dv_cyc !== exp_gap) begin failures++; $display("FAIL dv_to_req: got %0d exp %0d", cyc - dv_cyc, exp_gap); end
                end
                first_req = 0;
                repeat ($urandom_range(0, 2)) begin @(negedge clk); cyc++; end
                it_ack = 1'b1;
                if (spur_start) start = 1'b1;
                @(negedge clk); cyc++;
                it_ack = 1'b0; start = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(negedge clk); cyc++; end
                pdr = (st_dr.size() > 0) ? st_dr.pop_front() : 32'h0;
                pdc = (st_dc.size() > 0) ? st_dc.pop_front() : 32'h0;
                dr = pdr; dc = pdc; d_valid = 1'b1;
                checks++; if (level !== LW'(m_lvl)) begin failures++; $display("FAIL level: got %0d exp %0d", level, m_lvl); end
                checks++; if (iter_cnt !== IW'(m_it)) begin failures++; $display("FAIL iter_cnt: got %0d exp %0d", iter_cnt, m_it); end
                #1;
                checks++; if (acc_enable !== 1'b1) begin failures++; $display("FAIL acc_enable: got %b exp 1", acc_enable); end
                dv_cyc = cyc; m_acc++; m_it++; exp_gap = 3;
                c = is_small(pdr) && is_small(pdc);
                if (c || m_it == MI) begin
                    m_conv = c;
                    if (m_lvl == 0) m_fin = 1;
                    else begin m_lvl--; m_it = 0; exp_gap = 4; end
                end
                @(negedge clk); cyc++;
                d_valid = 1'b0; dr = $urandom; dc = $urandom;
            end else begin
                @(negedge clk); cyc++;
            end
        end
        checks++; if (!(seen_done && m_fin)) begin failures++; $display("FAIL done_seen: got done=%b model_fin=%b exp 1/1", seen_done, m_fin); end
        checks++; if (converged !== m_conv) begin failures++; $display("FAIL converged: got %b exp %b", converged, m_conv); end
        checks++; if (mon_acc !== m_acc) begin failures++; $display("FAIL acc_count: got %0d exp %0d", mon_acc, m_acc); end
        checks++; if (mon_shift !== NL - 1) begin failures++; $display("FAIL shift_count: got %0d exp %0d", mon_shift, NL - 1); end
        checks++; if (mon_overlap !== 0) begin failures++; $display("FAIL shift_acc_overlap: got %0d exp 0", mon_overlap); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_err_run: got %b exp 0", timeout_err); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL end_idle: got busy=%b done=%b exp 0/0", busy, done); end
        checks++; if (mon_done !== 1) begin failures++; $display("FAIL done_count: got %0d exp 1", mon_done); end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; it_ack = 1'b0; d_valid = 1'b0; dr = '0; dc = '0;
        #12;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done: got %b/%b exp 0/0", busy, done); end
        checks++; if (it_req !== 1'b0 || shift_d !== 1'b0) begin failures++; $display("FAIL rst_req_shift: got %b/%b exp 0/0", it_req, shift_d); end
        checks++; if (converged !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_conv_to: got %b/%b exp 0/0", converged, timeout_err); end
        checks++; if (level !== LW'(NL - 1)) begin failures++; $display("FAIL rst_level: got %0d exp %0d", level, NL - 1); end
        checks++; if (iter_cnt !== '0) begin failures++; $display("FAIL rst_iter: got %0d exp 0", iter_cnt); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_run;
        st_dr.delete(); st_dc.delete();
        fill_const(NL * MI, ONE, ONE);
        drive_run(0);
    endtask

    task automatic test_early_conv;
        st_dr.delete(); st_dc.delete();
        fill_const(1, ONE, ONE);
        fill_const(1, 32'h0, 32'h0);
        fill_const(2 * MI, ONE, ONE);
        drive_run(0);
    endtask

    task automatic test_boundary;
        st_dr.delete(); st_dc.delete();
        fill_const(1, 32'(-(EPS - 1)), 32'(EPS - 1));
        fill_const(1, 32'(EPS), 32'h0);
        fill_const(1, 32'h8000_0000, 32'h0);
        fill_const(1, 32'h0, 32'h0);
        fill_const(1, 32'h0, 32'(-EPS));
        fill_const(1, 32'h0, 32'h0);
        drive_run(0);
    endtask

    task automatic test_spurious;
        d_valid = 1'b1; dr = 32'h0; dc = 32'h0;
        #1;
        checks++; if (acc_enable !== 1'b0) begin failures++; $display("FAIL idle_acc_enable: got %b exp 0", acc_enable); end
        @(negedge clk); d_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_dvalid_busy: got %b exp 0", busy); end
        st_dr.delete(); st_dc.delete();
        fill_const(NL * MI, ONE, 32'h0);
        drive_run(1);
    endtask

    task automatic test_reset_mid;
        bit hit;
        hit = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (it_req) begin
                it_ack = 1'b1;
                @(negedge clk); it_ack = 1'b0;
                if (level == LW'(1)) begin hit = 1; break; end
                dr = ONE; dc = ONE; d_valid = 1'b1;
                @(negedge clk); d_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL reach_level1: got %b exp 1", hit); end
        dr = 32'h0; dc = 32'h0; d_valid = 1'b1; reset = 1'b1;
        #1;
        checks++; if (acc_enable !== 1'b0 || shift_d !== 1'b0) begin failures++; $display("FAIL rst_mid_glitch: got acc=%b shift=%b exp 0/0", acc_enable, shift_d); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || it_req !== 1'b0) begin failures++; $display("FAIL rst_mid_busy_req: got %b/%b exp 0/0", busy, it_req); end
        checks++; if (level !== LW'(NL - 1) || iter_cnt !== '0) begin failures++; $display("FAIL rst_mid_level_iter: got %0d/%0d exp %0d/0", level, iter_cnt, NL - 1); end
        reset = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        st_dr.delete(); st_dc.delete();
        fill_const(NL * MI, ONE, ONE);
        drive_run(0);
    endtask

    task automatic test_random;
        int kr, kc;
        for (int r = 0; r < 6; r++) begin
            st_dr.delete(); st_dc.delete();
            for (int i = 0; i < NL * MI; i++) begin
                kr = $urandom_range(0, 5);
                kc = ($urandom_range(0, 2) == 0) ? kr : $urandom_range(0, 5);
                if ($urandom_range(0, 3) == 0) begin kr = 1; kc = 1; end
                st_dr.push_back(gen_val(kr));
                st_dc.push_back(gen_val(kc));
            end
            drive_run(r[0]);
        end
    endtask

`ifdef LK_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        bit acked, seen;
        n = 0; acked = 0; seen = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; n = 1;
        for (int t = 0; t < 100; t++) begin
            if (done) begin seen = 1; break; end
            if (it_req && !acked) begin
                it_ack = 1'b1; acked = 1;
                @(negedge clk); it_ack = 1'b0; n++;
            end else begin
                @(negedge clk); n++;
            end
        end
        checks++; if (!seen || n !== TO) begin failures++; $display("FAIL timeout_done: got seen=%b cycles=%0d exp 1/%0d", seen, n, TO); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_set: got %b exp 1", timeout_err); end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_sticky: got err=%b busy=%b exp 1/0", timeout_err, busy); end
        st_dr.delete(); st_dc.delete();
        fill_const(NL * MI, ONE, ONE);
        drive_run(0);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_full_run();
        test_early_conv();
        test_boundary();
        test_spurious();
        test_reset_mid();
        test_random();
`ifdef LK_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lk_iter_ctrl.md
Name: lk_iter_ctrl

Overview:
Sequences the pyramidal LK displacement accumulator (sum_dr/sum_dc with enable/shift_d) across pyramid levels and refinement iterations. Runs coarsest to finest level. Per level:
- Requests up to MAX_ITER iterations from the It/G-inverse pipeline.
- Gates each returned (dr, dc) into the accumulator.
- Ends the level early on convergence.
- Pulses shift_d between levels so the accumulated flow is doubled for the next finer level.

Parameters:
NUM_LEVELS, 3, number of pyramid levels (>=1); level index runs NUM_LEVELS-1 down to 0
MAX_ITER, 5, maximum iterations per level (>=1)
MAX_D, 32, width of signed dr/dc increments (Q6.26)
EPS, 67109, convergence threshold on |dr| and |dc| in the same Q format (~0.001)
LVL_W, max(1,$clog2(NUM_LEVELS)), level output width
IT_W, $clog2(MAX_ITER+1), iteration counter width
TIMEOUT, 1024, watchdog cycles (used only with LK_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a flow estimate when idle
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at completion
level  out  LVL_W  current pyramid level
iter_cnt  out  IT_W  iterations completed in current level
it_req  out  1  request to pipeline for a new iteration at level
it_ack  in  1  pipeline accepts request
d_valid  in  1  dr/dc valid from pipeline (single-cycle)
dr  in  MAX_D  signed row increment
dc  in  MAX_D  signed column increment
acc_enable  out  1  to accumulator enable
shift_d  out  1  to accumulator shift_d
converged  out  1  last level ended by convergence rather than MAX_ITER
timeout_err  out  1  sticky watchdog error (constant 0 when feature is off)

Behaviour:
- Reset values: state IDLE; busy, done, it_req, shift_d, converged, timeout_err = 0; level = NUM_LEVELS-1; iter_cnt = 0.
- Reset is honoured mid-operation: state returns to IDLE immediately, with no shift_d or acc_enable glitch.
- All outputs are registered except acc_enable, which is combinational: acc_enable = d_valid && state==WAIT_D. The accumulator therefore captures dr/dc on the same edge.
- States:
  - IDLE: on start, load level = NUM_LEVELS-1, iter_cnt = 0, converged = 0, busy = 1, then go to REQ. A start pulse while not IDLE is ignored.
  - REQ: it_req = 1, held until it_ack. On the edge where it_req && it_ack, go to WAIT_D.
  - WAIT_D: on d_valid, register conv_flag = (|dr| < EPS) && (|dc| < EPS). Absolute value is computed at MAX_D+1 bits, so dr = -2^(MAX_D-1) is not converged. Increment iter_cnt and go to EVAL. d_valid in any other state is ignored and produces no acc_enable.
  - EVAL (1 cycle; the accumulator sum settles):
    - If conv_flag or iter_cnt==MAX_ITER, the level ends: converged <= conv_flag.
      - If level==0, go to FIN.
      - Otherwise go to SHIFT.
    - Otherwise go to REQ.
  - SHIFT: shift_d = 1 for exactly one cycle; level <= level-1; iter_cnt <= 0; then REQ.
  - FIN: done = 1 for one cycle, busy <= 0, then IDLE.
- With NUM_LEVELS=1, shift_d is never asserted.
- Counts per run: shift_d pulses exactly NUM_LEVELS-1 times; acc_enable pulses at most NUM_LEVELS*MAX_ITER times.
- Latency: start at edge 0 gives it_req high after edge 1. From d_valid to the next it_req is 2 cycles (EVAL, REQ), or 3 when a SHIFT is inserted.
- shift_d and acc_enable are never high in the same cycle.

Optional Feature:
LK_CTRL_TIMEOUT_EN:
- When defined:
  - A watchdog counts cycles spent in REQ+WAIT_D for the current iteration.
  - On reaching TIMEOUT without d_valid, set timeout_err (sticky until the next accepted start or reset), drop it_req, and go to FIN. done still pulses.
  - If d_valid arrives in the same cycle as expiry, d_valid wins.
- When undefined: no counter; timeout_err is tied to 0 and the FSM waits indefinitely.

Test Plan:
- Defaults; dr=dc=0x0400_0000 (1.0) on every iteration, it_ack and d_valid 2 cycles after each request -> 15 acc_enable pulses, 2 shift_d pulses, level sequence 2,1,0, done once, converged=0.
- Level 2 returns 1.0 then 0 -> level 2 ends after 2 iterations; shift_d pulses once and level becomes 1.
- Boundary values: dr=-(EPS-1), dc=EPS-1 -> converged at that iteration. dr=EPS -> not converged. dr=0x8000_0000 -> not converged.
- Spurious d_valid while IDLE, and start pulsed while busy -> no acc_enable, run unaffected.
- Reset asserted in WAIT_D at level 1 -> next cycle IDLE, busy=0, level=2, it_req=0; a following start runs normally.
- LK_CTRL_TIMEOUT_EN, TIMEOUT=16, it_ack given but no d_valid -> timeout_err=1 and done pulses after 16 cycles. A second start clears timeout_err.
